// File: rtl/pcie_us_pkg.sv
// Shared definitions for the UltraScale PCIe AXI-stream blocks.
// Default tuser widths, mux FSM states and the data-width check.
package pcie_us_pkg;

  localparam int RQ_USER_WIDTH_256 = 60;
  localparam int RQ_USER_WIDTH_512 = 137;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } rq_state_e;

  function automatic bit dw_legal(input int w);
    return (w == 64) || (w == 128) ||
           (w == 256) || (w == 512);
  endfunction

endpackage

// File: rtl/pcie_us_axis_rq_mux_if.sv
// Bundled RQ AXI stream, N lanes packed side by side.
// master drives the payload, slave drives tready.
interface pcie_us_axis_rq_mux_if
  import pcie_us_pkg::*;
#(
  parameter int N  = 1,
  parameter int DW = 256,
  parameter int KW = DW / 32,
  parameter int UW = (DW < 512) ? RQ_USER_WIDTH_256
                                : RQ_USER_WIDTH_512
);

  logic [N*DW-1:0] tdata;
  logic [N*KW-1:0] tkeep;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;
  logic [N-1:0]    tlast;
  logic [N*UW-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/pcie_axis_rr_arb.sv
// Request arbiter: round-robin by default, fixed priority
// when PCIE_RQ_MUX_PRIORITY_EN is defined (pointer removed).
module pcie_axis_rr_arb #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          take,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

`ifdef PCIE_RQ_MUX_PRIORITY_EN

  logic unused_arb;
  assign unused_arb = ^{clk, rst, take};

  // lowest requesting index wins
  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick       = '0;
        pick[j]    = 1'b1;
        pick_idx   = IW'(j);
        pick_valid = 1'b1;
      end
    end
  end

`else

  logic [IW-1:0] ptr;

  // first requester at or after ptr, wrapping
  always_comb begin
    logic [IW:0]   s;
    logic [IW-1:0] k;
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    s          = '0;
    k          = '0;
    for (int j = 0; j < N; j++) begin
      s = {1'b0, ptr} + (IW+1)'(j);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      k = s[IW-1:0];
      if (!pick_valid && req[k]) begin
        pick[k]    = 1'b1;
        pick_idx   = k;
        pick_valid = 1'b1;
      end
    end
  end

  // pointer moves just past the source granted
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take && pick_valid) begin
      ptr <= (pick_idx == IW'(N - 1)) ? '0
                                      : pick_idx + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/pcie_us_axis_rq_mux.sv
// RQ stream mux: frame-atomic arbitration onto one skid-buffered output.
// Define PCIE_RQ_MUX_PRIORITY_EN for fixed priority instead of round-robin.
module pcie_us_axis_rq_mux
  import pcie_us_pkg::*;
#(
  parameter int S_COUNT                 = 2,
  parameter int AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_RQ_USER_WIDTH =
    (AXIS_PCIE_DATA_WIDTH < 512) ? RQ_USER_WIDTH_256
                                 : RQ_USER_WIDTH_512
) (
  input  logic                       clk,
  input  logic                       rst,
  pcie_us_axis_rq_mux_if.slave       s_axis_rq,
  pcie_us_axis_rq_mux_if.master      m_axis_rq,
  input  logic                       enable,
  output logic [S_COUNT-1:0]         grant,
  output logic                       grant_valid
);

  localparam int DW = AXIS_PCIE_DATA_WIDTH;
  localparam int KW = AXIS_PCIE_KEEP_WIDTH;
  localparam int UW = AXIS_PCIE_RQ_USER_WIDTH;
  localparam int PW = DW + KW + UW + 1;
  localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  if (!dw_legal(DW)) begin : g_err_dw
    $error("pcie_us_axis_rq_mux: illegal data width %0d", DW);
  end
  if (KW * 32 != DW) begin : g_err_kw
    $error("pcie_us_axis_rq_mux: keep width %0d mismatch", KW);
  end
  if (S_COUNT < 1) begin : g_err_sc
    $error("pcie_us_axis_rq_mux: S_COUNT %0d < 1", S_COUNT);
  end

  rq_state_e          state;
  logic [IW-1:0]      idx;
  logic [S_COUNT-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               arb_take;

  logic               ready_int_reg;
  logic               ready_int_early;
  logic               valid_int;
  logic               sel_valid;
  logic               sel_last;
  logic [PW-1:0]      pay_int;

  logic               m_rdy;
  logic               m_tvalid_reg;
  logic               tmp_tvalid;
  logic [PW-1:0]      m_pay;
  logic [PW-1:0]      tmp_pay;

  pcie_axis_rr_arb #(
    .N (S_COUNT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (s_axis_rq.tvalid),
    .take       (arb_take),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign arb_take  = (state == ST_IDLE) && enable && pick_valid;
  assign sel_valid = s_axis_rq.tvalid[idx];
  assign sel_last  = s_axis_rq.tlast[idx];
  assign valid_int = grant_valid && enable &&
                     ready_int_reg && sel_valid;

  assign s_axis_rq.tready =
    grant & {S_COUNT{enable && ready_int_reg}};

  assign pay_int = {
    s_axis_rq.tdata[idx*DW +: DW],
    s_axis_rq.tkeep[idx*KW +: KW],
    s_axis_rq.tuser[idx*UW +: UW],
    sel_last
  };

  // frame ownership: grant at a boundary, release on the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      idx         <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arb_take) begin
            state       <= ST_ACTIVE;
            grant       <= pick;
            grant_valid <= 1'b1;
            idx         <= pick_idx;
          end
        end
        ST_ACTIVE: begin
          if (valid_int && sel_last) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m_rdy = m_axis_rq.tready[0];

  assign ready_int_early =
    (m_rdy && m_tvalid_reg) ||
    (!tmp_tvalid && (!m_tvalid_reg || !valid_int));

  // skid valid flags and registered input ready
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_reg  <= 1'b0;
      tmp_tvalid    <= 1'b0;
      ready_int_reg <= 1'b0;
    end else begin
      ready_int_reg <= ready_int_early;
      if (ready_int_reg) begin
        if (m_rdy || !m_tvalid_reg) begin
          m_tvalid_reg <= valid_int;
        end else begin
          tmp_tvalid <= valid_int;
        end
      end else if (m_rdy) begin
        m_tvalid_reg <= tmp_tvalid;
        tmp_tvalid   <= 1'b0;
      end
    end
  end

  // skid payload follows the same steering as the flags
  always_ff @(posedge clk) begin
    if (ready_int_reg) begin
      if (m_rdy || !m_tvalid_reg) begin
        m_pay <= pay_int;
      end else begin
        tmp_pay <= pay_int;
      end
    end else if (m_rdy) begin
      m_pay <= tmp_pay;
    end
  end

  assign m_axis_rq.tvalid = m_tvalid_reg;
  assign {m_axis_rq.tdata, m_axis_rq.tkeep,
          m_axis_rq.tuser, m_axis_rq.tlast} = m_pay;

endmodule

// File: tb/tb_pcie_us_axis_rq_mux.sv
// Bench for pcie_us_axis_rq_mux: directed vector table,
// hand sequences and random traffic against a frame-level model.
module tb_pcie_us_axis_rq_mux;
  import pcie_us_pkg::*;

  localparam int S  = 4;
  localparam int DW = 64;
  localparam int KW = 2;
  localparam int UW = 60;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic       tv;
    logic [7:0] d;
    logic       last;
    logic       mr;
    logic       en;
    logic [S-1:0] g;
    logic       gv;
    logic [S-1:0] rdy;
    logic       mv;
    logic [7:0] md;
    logic       ml;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [S-1:0] grant;
  logic grant_valid;

  pcie_us_axis_rq_mux_if #(.N(S), .DW(DW), .KW(KW), .UW(UW)) s_if ();
  pcie_us_axis_rq_mux_if #(.N(1), .DW(DW), .KW(KW), .UW(UW)) m_if ();

  pcie_us_axis_rq_mux #(
    .S_COUNT                 (S),
    .AXIS_PCIE_DATA_WIDTH    (DW),
    .AXIS_PCIE_KEEP_WIDTH    (KW),
    .AXIS_PCIE_RQ_USER_WIDTH (UW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis_rq   (s_if),
    .m_axis_rq   (m_if),
    .enable      (enable),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  beat_t src_q[S][$];
  beat_t acc_q[$];
  bit    m_busy;
  int    m_owner;
  int    m_ptr;
  int    glog[$];
  int    gcyc[$];
  int    cyc;
  bit    prev_stall;
  beat_t prev_beat;
  int    bubble_pct, mrdy_pct, en_low_pct;
  vec_t  tbl[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [S-1:0] onehot(input int k);
    logic [S-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic beat_t mkbeat(input logic [7:0] d,
                                   input logic l);
    beat_t b;
    b.data = {56'h0, d};
    b.keep = 2'b11;
    b.user = {52'h0, d};
    b.last = l;
    return b;
  endfunction

  function automatic beat_t rbeat(input logic l);
    beat_t b;
    b.data = {$urandom(), $urandom()};
    b.keep = 2'($urandom_range(3));
    b.user = UW'({$urandom(), $urandom()});
    b.last = l;
    return b;
  endfunction

  function automatic vec_t mkv(
    input logic tv, input logic [7:0] d, input logic l,
    input logic mr, input logic en, input logic [S-1:0] g,
    input logic gv, input logic [S-1:0] rdy, input logic mv,
    input logic [7:0] md, input logic ml);
    vec_t v;
    v.tv = tv; v.d = d; v.last = l; v.mr = mr; v.en = en;
    v.g = g; v.gv = gv; v.rdy = rdy; v.mv = mv;
    v.md = md; v.ml = ml;
    return v;
  endfunction

  task automatic drive_beat(input int i, input beat_t b,
                            input logic v);
    s_if.tvalid[i]         = v;
    s_if.tlast[i]          = b.last;
    s_if.tdata[i*DW +: DW] = b.data;
    s_if.tkeep[i*KW +: KW] = b.keep;
    s_if.tuser[i*UW +: UW] = b.user;
  endtask

  task automatic drive_idle();
    for (int i = 0; i < S; i++) drive_beat(i, '0, 1'b0);
  endtask

  function automatic beat_t get_out();
    beat_t b;
    b.data = m_if.tdata;
    b.keep = m_if.tkeep;
    b.user = m_if.tuser;
    b.last = m_if.tlast[0];
    return b;
  endfunction

  function automatic int arb_pick(input logic [S-1:0] tv);
`ifdef PCIE_RQ_MUX_PRIORITY_EN
    for (int j = 0; j < S; j++) if (tv[j]) return j;
`else
    for (int j = 0; j < S; j++)
      if (tv[(m_ptr + j) % S]) return (m_ptr + j) % S;
`endif
    return 0;
  endfunction

  task automatic model_clear();
    m_busy = 0;
    m_owner = 0;
    m_ptr = 0;
    prev_stall = 0;
    acc_q.delete();
    for (int i = 0; i < S; i++) src_q[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic add_frame(input int src, input int len);
    for (int b = 0; b < len; b++)
      src_q[src].push_back(rbeat(b == len - 1));
  endtask

  task automatic auto_cycle();
    logic [S-1:0] tv, rdy, own;
    beat_t ob, b;
    bit was_busy;
    int w;
    for (int i = 0; i < S; i++) begin
      tv[i] = (src_q[i].size() > 0) &&
              ($urandom_range(99) >= bubble_pct);
      if (src_q[i].size() > 0) drive_beat(i, src_q[i][0], tv[i]);
      else drive_beat(i, '0, 1'b0);
    end
    m_if.tready[0] = ($urandom_range(99) < mrdy_pct);
    enable = ($urandom_range(99) >= en_low_pct);
    #4;
    cyc++;
    own = m_busy ? onehot(m_owner) : '0;
    chk("grant", grant, own);
    chk("grant_valid", grant_valid, m_busy);
    rdy = s_if.tready;
    chk("stray_tready", rdy & ~(enable ? own : '0), 0);
    ob = get_out();
    if (prev_stall)
      chk("out_hold", {m_if.tvalid[0], ob}, {1'b1, prev_beat});
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      if (acc_q.size() == 0) fail("unexpected_out_beat");
      else chk("out_beat", ob, acc_q.pop_front());
    end
    prev_stall = m_if.tvalid[0] && !m_if.tready[0];
    prev_beat = ob;
    was_busy = m_busy;
    for (int i = 0; i < S; i++) begin
      if (tv[i] && rdy[i]) begin
        b = src_q[i].pop_front();
        acc_q.push_back(b);
        if (was_busy && i == m_owner && b.last) m_busy = 0;
      end
    end
    if (!was_busy && enable && (|tv)) begin
      w = arb_pick(tv);
      m_busy = 1;
      m_owner = w;
      glog.push_back(w);
      gcyc.push_back(cyc);
`ifndef PCIE_RQ_MUX_PRIORITY_EN
      m_ptr = (w + 1) % S;
`endif
    end
    @(negedge clk);
  endtask

  function automatic bit pending();
    for (int i = 0; i < S; i++) if (src_q[i].size() > 0) return 1;
    return (acc_q.size() > 0);
  endfunction

  task automatic run_auto(input string nm, input int budget);
    int n;
    n = 0;
    while ((pending() || m_busy) && n < budget) begin
      auto_cycle();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got %0d cycles want < %0d",
               nm, n, budget);
    end
  endtask

  initial begin
    int exp2[4];
    drive_idle();
    m_if.tready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_tready", s_if.tready, 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // 3-beat frame, enable pause, output backpressure
    tbl.push_back(mkv(1,8'hA0,0,1,1, 0,0,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hA0,0,1,1, 1,1,1, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hA1,0,1,1, 1,1,1, 1,8'hA0,0));
    tbl.push_back(mkv(1,8'hA2,1,1,1, 1,1,1, 1,8'hA1,0));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 1,8'hA2,1));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB0,0,1,1, 0,0,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB0,0,1,1, 1,1,1, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB1,0,1,0, 1,1,0, 1,8'hB0,0));
    tbl.push_back(mkv(1,8'hB1,0,1,0, 1,1,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB1,0,1,0, 1,1,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB1,0,1,1, 1,1,1, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hB2,0,1,1, 1,1,1, 1,8'hB1,0));
    tbl.push_back(mkv(1,8'hB3,1,1,1, 1,1,1, 1,8'hB2,0));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 1,8'hB3,1));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hC0,0,1,1, 0,0,0, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hC0,0,1,1, 1,1,1, 0,8'h00,0));
    tbl.push_back(mkv(1,8'hC1,0,1,1, 1,1,1, 1,8'hC0,0));
    tbl.push_back(mkv(1,8'hC2,0,0,1, 1,1,1, 1,8'hC1,0));
    tbl.push_back(mkv(1,8'hC3,1,0,1, 1,1,0, 1,8'hC1,0));
    tbl.push_back(mkv(1,8'hC3,1,1,1, 1,1,0, 1,8'hC1,0));
    tbl.push_back(mkv(1,8'hC3,1,1,1, 1,1,1, 1,8'hC2,0));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 1,8'hC3,1));
    tbl.push_back(mkv(0,8'h00,0,1,1, 0,0,0, 0,8'h00,0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive_idle();
      drive_beat(0, mkbeat(tbl[r].d, tbl[r].last), tbl[r].tv);
      m_if.tready[0] = tbl[r].mr;
      enable = tbl[r].en;
      #4;
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].g);
      chk($sformatf("tbl%0d_gvalid", r), grant_valid, tbl[r].gv);
      chk($sformatf("tbl%0d_tready", r), s_if.tready, tbl[r].rdy);
      chk($sformatf("tbl%0d_mvalid", r), m_if.tvalid, tbl[r].mv);
      if (tbl[r].mv)
        chk($sformatf("tbl%0d_mbeat", r), get_out(),
            mkbeat(tbl[r].md, tbl[r].ml));
      @(negedge clk);
    end

    // two sources streaming 2-beat frames
    do_reset();
    bubble_pct = 0; mrdy_pct = 100; en_low_pct = 0;
    add_frame(0, 2); add_frame(0, 2);
    add_frame(1, 2); add_frame(1, 2);
    glog.delete();
    run_auto("rr2", 200);
`ifdef PCIE_RQ_MUX_PRIORITY_EN
    exp2 = '{0, 0, 1, 1};
`else
    exp2 = '{0, 1, 0, 1};
`endif
    chk("rr2_count", glog.size(), 4);
    for (int k = 0; k < glog.size() && k < 4; k++)
      chk($sformatf("rr2_order%0d", k), glog[k], exp2[k]);

    // four single-beat frames arriving together
    do_reset();
    for (int i = 0; i < S; i++) add_frame(i, 1);
    glog.delete();
    gcyc.delete();
    run_auto("single4", 200);
    chk("single4_count", glog.size(), 4);
    for (int k = 0; k < glog.size() && k < 4; k++)
      chk($sformatf("single4_order%0d", k), glog[k], k);
    for (int k = 1; k < gcyc.size() && k < 4; k++)
      chk($sformatf("single4_gap%0d", k), gcyc[k] - gcyc[k-1], 2);

    // reset in the middle of a frame
    do_reset();
    add_frame(2, 3);
    for (int n = 0; n < 20 && src_q[2].size() > 2; n++) auto_cycle();
    chk("midrst_beat1_taken", src_q[2].size(), 2);
    drive_beat(2, src_q[2][0], 1'b1);
    rst = 1'b1;
    #4;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #4;
    chk("midrst_mvalid", m_if.tvalid, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_gvalid", grant_valid, 0);
    chk("midrst_tready", s_if.tready, 0);
    @(negedge clk);
    model_clear();
    add_frame(1, 2);
    run_auto("midrst_fresh", 100);

    // random traffic
    do_reset();
    bubble_pct = 20; mrdy_pct = 70; en_low_pct = 5;
    for (int batch = 0; batch < 4; batch++) begin
      for (int f = 0; f < 20; f++)
        add_frame($urandom_range(S - 1), $urandom_range(4, 1));
      run_auto($sformatf("rand%0d", batch), 3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_us_axis_rq_mux.md
# pcie_us_axis_rq_mux

Arbitrating multiplexer for the UltraScale PCIe requester request (RQ) AXI stream. It merges S_COUNT upstream request sources (DMA read engine, DMA write engine, MSI generator, ...) onto the single RQ interface of the PCIe hard core. It is the outbound counterpart of the RC completion demux. Arbitration happens only at TLP boundaries, and a granted source owns the output until its tlast beat transfers.

## Interface
- S_COUNT, 2: number of input sources, 1..16
- AXIS_PCIE_DATA_WIDTH, 256: data width; legal values 64/128/256/512
- AXIS_PCIE_KEEP_WIDTH, AXIS_PCIE_DATA_WIDTH/32: tkeep width, one bit per dword
- AXIS_PCIE_RQ_USER_WIDTH, (AXIS_PCIE_DATA_WIDTH<512 ? 60 : 137): tuser width

Ports:
- clk  in  1  clock; the only clock in the block
- rst  in  1  synchronous, active-high reset
- s_axis_rq_tdata  in  S_COUNT*AXIS_PCIE_DATA_WIDTH  packed input data, source i at slice i
- s_axis_rq_tkeep  in  S_COUNT*AXIS_PCIE_KEEP_WIDTH  input tkeep
- s_axis_rq_tvalid  in  S_COUNT  input valid
- s_axis_rq_tready  out  S_COUNT  input ready
- s_axis_rq_tlast  in  S_COUNT  input last
- s_axis_rq_tuser  in  S_COUNT*AXIS_PCIE_RQ_USER_WIDTH  input user
- m_axis_rq_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  single-stream widths  output to the PCIe core
- enable  in  1  when low, no new grant is issued and all s_axis_rq_tready are forced low
- grant  out  S_COUNT  one-hot current owner; zero when idle
- grant_valid  out  1  a frame is in progress

## Operation
- The state machine has two states, IDLE and ACTIVE.
  - IDLE: if enable is high and any tvalid is high, pick a winner, register it in grant, set grant_valid, and go to ACTIVE.
  - ACTIVE: only the granted source may transfer. When the granted source's tvalid, tready and tlast are all high in the same cycle, clear grant and grant_valid and return to IDLE.
- Round-robin policy (default):
  - The priority pointer resets to 0.
  - The search starts at the pointer and wraps modulo S_COUNT; the first source with tvalid high wins.
  - After granting source k, the pointer becomes (k+1) mod S_COUNT.
- s_axis_rq_tready[i] = grant[i] && enable && ready_int_reg. All non-granted ready bits are 0.
- Beat forwarding: the accepted beat is sent to a two-register output skid buffer (output register plus temp register).
  - ready_int_early = (m_tready && m_tvalid) || (!temp_valid && (!m_tvalid || !valid_int)).
  - ready_int_reg is the registered copy of ready_int_early.
- The payload (tdata, tkeep, tlast, tuser) is passed through unmodified. The block does no TLP inspection.
- enable falling mid-frame pauses the frame: tready goes low but the grant is held. The frame resumes when enable returns high.
- An input tvalid drop mid-frame is a legal bubble. The grant is held.
- S_COUNT=1 degenerates to a registered pass-through with the same framing.

## Timing
- Reset values: every output tvalid 0, every s_axis_rq_tready 0, grant 0, grant_valid 0, pointer 0, skid temp register empty.
- Arbitration takes 1 cycle: a request seen in IDLE in cycle N gives grant in cycle N+1, and the first beat can be accepted in N+1.
- Data latency: a beat accepted in cycle N appears on m_axis_rq in cycle N+1.
- Throughput: 1 beat per cycle within a frame. There is 1 idle input cycle between consecutive frames (the IDLE re-arbitration cycle).
- Once m_tvalid is high, the output beat is held stable until m_tready is high. This is the AXI-Stream rule with no retraction.
- A single-beat frame (tlast on the first beat) is accepted in N+1 and the block is IDLE in N+2.
- Reset mid-frame: all state clears on the next edge and any buffered beats are discarded.

## Configuration
- PCIE_RQ_MUX_PRIORITY_EN:
  - When defined, arbitration is fixed priority: the lowest index with tvalid high wins and the pointer logic is removed.
  - When not defined, arbitration is round-robin as described above.
- Framing, latency and the skid buffer are identical in both modes.

## Structure
- Shared package pcie_us_pkg holds:
  - width-default constants RQ_USER_WIDTH_256 = 60 and RQ_USER_WIDTH_512 = 137
  - the legal data-width check
- One sub-module, pcie_axis_rr_arb: a pure arbiter with request/grant/pointer logic and the PRIORITY_EN option. It is reusable by the future CQ/CC muxes.
- The skid buffer stays inline.
- Elaboration errors: AXIS_PCIE_DATA_WIDTH not legal, KEEP_WIDTH*32 != DATA_WIDTH, or S_COUNT < 1.

## Test plan
- Single source 0 sends a 3-beat TLP with tdata=0xA0,0xA1,0xA2 and m_tready=1 -> grant=01 for 3 cycles; the output shows the same beats with 1-cycle latency and tlast on 0xA2.
- Sources 0 and 1 both continuously sending 2-beat TLPs, round-robin build -> grant order 0,1,0,1 with no frame interleaving; with PCIE_RQ_MUX_PRIORITY_EN defined, source 0 wins every arbitration.
- m_tready toggles 1,0,0,1 during a 4-beat frame -> no beat lost or duplicated, at most one beat held in temp, and s_tready low one cycle after backpressure.
- enable dropped for 3 cycles during beat 2 of a 4-beat frame -> all tready 0, grant held, frame completes unchanged after enable returns.
- Single-beat TLPs from 4 sources arriving in the same cycle -> one beat per 2 cycles, grant order 0,1,2,3.
- rst asserted on beat 2 of a frame -> next cycle m_tvalid=0, grant=0, s_tready=0; a fresh TLP afterwards goes through correctly.
